// File: rtl/motion_pkg.sv
// Shared types and arithmetic helpers for the multi-axis motion integrator.
package motion_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StVel  = 2'd1;
  localparam state_t StPos  = 2'd2;
  localparam state_t StDone = 2'd3;

  // Wide signed carrier for sums; exact for any WIDTH up to 63 bits.
  typedef logic signed [63:0] wide_t;

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input wide_t lim);
    wide_t s;
    s = a + b;
    if (s > lim) begin
      return lim;
    end else if (s < -lim) begin
      return -lim;
    end
    return s;
  endfunction

  // Floor conversion from fixed-point to integer.
  function automatic wide_t to_int(input wide_t raw, input int unsigned shift);
    return raw >>> shift;
  endfunction

endpackage

// File: rtl/axis_clamp.sv
// Wall clamp for one axis: stop or reflect when the tentative position leaves [lo, hi].
module axis_clamp
  import motion_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  wide_t                   s_i,
  input  logic signed [WIDTH-1:0] v_i,
  input  logic                    bounce_i,
  input  wide_t                   lo_i,
  input  wide_t                   hi_i,
  output logic signed [WIDTH-1:0] pos_o,
  output logic signed [WIDTH-1:0] vel_o,
  output logic                    hit_o
);

  always_comb begin
    pos_o = WIDTH'(s_i);
    vel_o = v_i;
    hit_o = 1'b0;
    if (s_i < lo_i) begin
      pos_o = WIDTH'(lo_i);
      vel_o = bounce_i ? -v_i : '0;
      hit_o = 1'b1;
    end else if (s_i > hi_i) begin
      pos_o = WIDTH'(hi_i);
      vel_o = bounce_i ? -v_i : '0;
      hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/motion_integrator_axes.sv
// Multi-axis kinematics integrator sharing one adder path across axes via a small FSM.
// Optional velocity damping is built when MOTION_INTEGRATOR_FRICTION_EN is defined.
module motion_integrator_axes
  import motion_pkg::*;
#(
  parameter int NUM_AXES       = 2,
  parameter int WIDTH          = 32,
  parameter int POSITION_SHIFT = 4,
  parameter int RST_VALUE      = 50,
  parameter int POS_MIN        = 0,
  parameter int POS_MAX        = 100,
  parameter int VEL_LIMIT      = 64,
  parameter int FRICTION_SHIFT = 4
) (
  input  logic                      CLK,
  input  logic                      i_rst,
  input  logic                      i_calc_time,
  input  logic                      i_load,
  input  logic [NUM_AXES*WIDTH-1:0] i_load_pos,
  input  logic [NUM_AXES*WIDTH-1:0] i_accel,
  input  logic                      i_bounce_mode,
  output logic [NUM_AXES*WIDTH-1:0] o_pos,
  output logic [NUM_AXES*WIDTH-1:0] o_vel,
  output logic [NUM_AXES-1:0]       o_hit,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned AxW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam wide_t RstRaw = wide_t'(RST_VALUE) <<< POSITION_SHIFT;
  localparam wide_t LoRaw  = wide_t'(POS_MIN) <<< POSITION_SHIFT;
  localparam wide_t HiRaw  = wide_t'(POS_MAX) <<< POSITION_SHIFT;
  localparam wide_t VelLim = wide_t'(VEL_LIMIT);

  state_t                  state_q, state_d;
  logic [AxW-1:0]          k_q, k_d;
  logic signed [WIDTH-1:0] pos_q [NUM_AXES];
  logic signed [WIDTH-1:0] pos_d [NUM_AXES];
  logic signed [WIDTH-1:0] vel_q [NUM_AXES];
  logic signed [WIDTH-1:0] vel_d [NUM_AXES];
  logic [NUM_AXES-1:0]     hit_acc_q, hit_acc_d;
  logic [NUM_AXES-1:0]     hit_q, hit_d;
  logic                    done_q, done_d;

  logic signed [WIDTH-1:0] accel_w [NUM_AXES];
  logic signed [WIDTH-1:0] load_w  [NUM_AXES];

  always_comb begin
    for (int k = 0; k < NUM_AXES; k++) begin
      accel_w[k] = signed'(i_accel[k*WIDTH +: WIDTH]);
      load_w[k]  = signed'(i_load_pos[k*WIDTH +: WIDTH]);
    end
  end

  // Shared datapath: the axis selected by k_q feeds both the VEL and POS steps.
  wide_t                   cur_v, cur_a, vel_incr, pos_sum;
  logic signed [WIDTH-1:0] vel_next;
  logic signed [WIDTH-1:0] clamp_pos, clamp_vel;
  logic                    clamp_hit;

  always_comb begin
    cur_v = wide_t'(vel_q[k_q]);
    cur_a = wide_t'(accel_w[k_q]);
`ifdef MOTION_INTEGRATOR_FRICTION_EN
    vel_incr = cur_a - (cur_v >>> FRICTION_SHIFT);
`else
    vel_incr = cur_a;
`endif
    vel_next = WIDTH'(sat_add(cur_v, vel_incr, VelLim));
    pos_sum  = wide_t'(pos_q[k_q]) + cur_v;
  end

  axis_clamp #(
    .WIDTH (WIDTH)
  ) u_axis_clamp (
    .s_i      (pos_sum),
    .v_i      (vel_q[k_q]),
    .bounce_i (i_bounce_mode),
    .lo_i     (LoRaw),
    .hi_i     (HiRaw),
    .pos_o    (clamp_pos),
    .vel_o    (clamp_vel),
    .hit_o    (clamp_hit)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pos_d     = pos_q;
    vel_d     = vel_q;
    hit_acc_d = hit_acc_q;
    hit_d     = hit_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_calc_time) begin
          state_d   = StVel;
          k_d       = '0;
          hit_acc_d = '0;
        end
      end
      StVel: begin
        vel_d[k_q] = vel_next;
        state_d    = StPos;
      end
      StPos: begin
        pos_d[k_q]     = clamp_pos;
        vel_d[k_q]     = clamp_vel;
        hit_acc_d[k_q] = hit_acc_q[k_q] | clamp_hit;
        if (k_q == AxW'(NUM_AXES - 1)) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + AxW'(1);
          state_d = StVel;
        end
      end
      default: begin
        hit_d   = hit_acc_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
    endcase

    // Load overrides everything, including an in-flight pass and a same-cycle tick.
    if (i_load) begin
      for (int k = 0; k < NUM_AXES; k++) begin
        pos_d[k] = WIDTH'(wide_t'(load_w[k]) <<< POSITION_SHIFT);
        vel_d[k] = '0;
      end
      hit_d     = '0;
      hit_acc_d = '0;
      done_d    = 1'b0;
      k_d       = '0;
      state_d   = StIdle;
    end
  end

  always_ff @(posedge CLK or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      hit_acc_q <= '0;
      hit_q     <= '0;
      done_q    <= 1'b0;
      for (int k = 0; k < NUM_AXES; k++) begin
        pos_q[k] <= WIDTH'(RstRaw);
        vel_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      hit_acc_q <= hit_acc_d;
      hit_q     <= hit_d;
      done_q    <= done_d;
      for (int k = 0; k < NUM_AXES; k++) begin
        pos_q[k] <= pos_d[k];
        vel_q[k] <= vel_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_AXES; k++) begin
      o_pos[k*WIDTH +: WIDTH] = WIDTH'(to_int(wide_t'(pos_q[k]), POSITION_SHIFT));
      o_vel[k*WIDTH +: WIDTH] = vel_q[k];
    end
  end

  assign o_hit  = hit_q;
  assign o_busy = (state_q != StIdle);
  assign o_done = done_q;

endmodule

// File: tb/tb_motion_integrator_axes.sv
// Self-checking bench for motion_integrator_axes: directed wall/saturation/abort cases plus
// randomized ticks and loads against a behavioural per-axis kinematics model.
module tb_motion_integrator_axes;

  localparam int N = 2;
  localparam int W = 32;
`ifdef MOTION_INTEGRATOR_FRICTION_EN
  localparam bit Fric = 1'b1;
`else
  localparam bit Fric = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           calc;
  logic           load;
  logic [N*W-1:0] load_pos;
  logic [N*W-1:0] accel;
  logic           bounce;
  logic [N*W-1:0] pos;
  logic [N*W-1:0] vel;
  logic [N-1:0]   hit;
  logic           busy;
  logic           done;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model state: raw fixed-point position/velocity and last-tick hit flags.
  longint mpos [N];
  longint mvel [N];
  logic [N-1:0] mhit;

  motion_integrator_axes dut (
    .CLK           (clk),
    .i_rst         (rst),
    .i_calc_time   (calc),
    .i_load        (load),
    .i_load_pos    (load_pos),
    .i_accel       (accel),
    .i_bounce_mode (bounce),
    .o_pos         (pos),
    .o_vel         (vel),
    .o_hit         (hit),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic signed [W-1:0] pos_of(input int k);
    return signed'(pos[k*W +: W]);
  endfunction

  function automatic logic signed [W-1:0] vel_of(input int k);
    return signed'(vel[k*W +: W]);
  endfunction

  task automatic do_load(input int p0, input int p1);
    @(negedge clk);
    load = 1'b1;
    load_pos = {W'(p1), W'(p0)};
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Pulses the tick and waits (bounded) for o_done; reports edges from the tick edge.
  task automatic do_tick(input int a0, input int a1, input logic b,
                         output int cycles, output bit got);
    @(negedge clk);
    accel = {W'(a1), W'(a0)};
    bounce = b;
    calc = 1'b1;
    @(posedge clk);
    #1 calc = 1'b0;
    cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 cycles++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic model_load(input int p0, input int p1);
    mpos[0] = longint'(p0) * 16;
    mpos[1] = longint'(p1) * 16;
    mvel[0] = 0;
    mvel[1] = 0;
    mhit = '0;
  endtask

  task automatic model_tick(input int a0, input int a1, input logic b);
    longint a [N];
    longint v, s;
    a[0] = a0;
    a[1] = a1;
    mhit = '0;
    for (int k = 0; k < N; k++) begin
      v = mvel[k] + a[k] - (Fric ? (mvel[k] >>> 4) : 64'sd0);
      if (v > 64) v = 64;
      if (v < -64) v = -64;
      s = mpos[k] + v;
      if (s < 0 || s > 1600) begin
        mpos[k] = (s < 0) ? 0 : 1600;
        v = b ? -v : 0;
        mhit[k] = 1'b1;
      end else begin
        mpos[k] = s;
      end
      mvel[k] = v;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      tests_run++;
      if (pos_of(k) !== 32'sd50 || vel_of(k) !== 32'sd0) begin
        tests_failed++;
        $display("FAIL reset_axis%0d pos=%0d vel=%0d want pos=50 vel=0", k, pos_of(k), vel_of(k));
      end
    end
    tests_run++;
    if ({hit, busy, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags hit=%b busy=%b done=%b want 0", hit, busy, done);
    end
  endtask

  task automatic test_tick_latency();
    int c;
    bit g;
    do_tick(16, -16, 1'b0, c, g);
    tests_run++;
    if (!g || c !== 5) begin
      tests_failed++;
      $display("FAIL latency got=%0d cycles=%0d want done at 5", g, c);
    end
    tests_run++;
    if (vel_of(0) !== 32'sd16 || vel_of(1) !== -32'sd16 || pos_of(0) !== 32'sd51 ||
        pos_of(1) !== 32'sd49 || hit !== 2'b00) begin
      tests_failed++;
      $display("FAIL tick1 vel=%0d,%0d pos=%0d,%0d hit=%b want 16,-16 51,49 00",
               vel_of(0), vel_of(1), pos_of(0), pos_of(1), hit);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_stop_wall();
    int c;
    bit g;
    do_load(99, 0);
    do_tick(32, 0, 1'b0, c, g);
    tests_run++;
    if (!g || pos_of(0) !== 32'sd100 || vel_of(0) !== 32'sd0 || hit[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL stop_wall done=%0d pos=%0d vel=%0d hit=%b want 1 100 0 1",
               g, pos_of(0), vel_of(0), hit[0]);
    end
  endtask

  task automatic test_bounce_wall();
    int c;
    bit g;
    do_load(0, 1);
    do_tick(0, -48, 1'b1, c, g);
    tests_run++;
    if (!g || pos_of(1) !== 32'sd0 || vel_of(1) !== 32'sd48 || hit !== 2'b10) begin
      tests_failed++;
      $display("FAIL bounce_wall done=%0d pos=%0d vel=%0d hit=%b want 1 0 48 10",
               g, pos_of(1), vel_of(1), hit);
    end
    do_load(5, 5);
    tests_run++;
    if (hit !== 2'b00) begin
      tests_failed++;
      $display("FAIL load_clears_hit hit=%b want 00", hit);
    end
  endtask

  task automatic test_saturation();
    int c;
    bit g;
    do_load(50, 50);
    do_tick(100, -100, 1'b0, c, g);
    tests_run++;
    if (!g || vel_of(0) !== 32'sd64 || vel_of(1) !== -32'sd64 ||
        pos_of(0) !== 32'sd54 || pos_of(1) !== 32'sd46) begin
      tests_failed++;
      $display("FAIL saturation vel=%0d,%0d pos=%0d,%0d want 64,-64 54,46",
               vel_of(0), vel_of(1), pos_of(0), pos_of(1));
    end
  endtask

  task automatic test_abort();
    int dones;
    @(negedge clk);
    accel = {W'(32'sd20), W'(32'sd20)};
    calc = 1'b1;
    @(posedge clk);
    #1 calc = 1'b0;
    load = 1'b1;
    load_pos = {W'(32'sd20), W'(32'sd10)};
    @(posedge clk);
    #1 load = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || pos_of(0) !== 32'sd10 || pos_of(1) !== 32'sd20 ||
        vel_of(0) !== 32'sd0 || vel_of(1) !== 32'sd0) begin
      tests_failed++;
      $display("FAIL abort_state busy=%b pos=%0d,%0d vel=%0d,%0d want 0 10,20 0,0",
               busy, pos_of(0), pos_of(1), vel_of(0), vel_of(1));
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done dones=%0d want 0", dones);
    end
  endtask

  task automatic test_busy_ignore();
    int dones;
    do_load(50, 50);
    @(negedge clk);
    accel = '0;
    calc = 1'b1;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1 if (done) dones++;
      if (i == 2) calc = 1'b0;
    end
    tests_run++;
    if (dones !== 1) begin
      tests_failed++;
      $display("FAIL busy_ignore dones=%0d want 1", dones);
    end
  endtask

  task automatic test_friction();
    int c;
    bit g;
    do_load(50, 50);
    do_tick(32, 0, 1'b0, c, g);
    do_tick(0, 0, 1'b0, c, g);
    tests_run++;
    if (!g || vel_of(0) !== (Fric ? 32'sd30 : 32'sd32)) begin
      tests_failed++;
      $display("FAIL friction done=%0d vel=%0d want %0d", g, vel_of(0), Fric ? 30 : 32);
    end
  endtask

  task automatic test_random();
    int c;
    bit g;
    int a0, a1, p0, p1;
    logic b;
    do_load(50, 50);
    model_load(50, 50);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(4) == 0) begin
        p0 = int'($urandom_range(140)) - 20;
        p1 = int'($urandom_range(140)) - 20;
        do_load(p0, p1);
        model_load(p0, p1);
        g = 1'b1;
      end else begin
        a0 = int'($urandom_range(160)) - 80;
        a1 = int'($urandom_range(160)) - 80;
        b = 1'($urandom_range(1));
        do_tick(a0, a1, b, c, g);
        model_tick(a0, a1, b);
      end
      tests_run++;
      if (!g || pos_of(0) !== 32'(mpos[0] >>> 4) || pos_of(1) !== 32'(mpos[1] >>> 4) ||
          vel_of(0) !== 32'(mvel[0]) || vel_of(1) !== 32'(mvel[1]) || hit !== mhit) begin
        tests_failed++;
        $display("FAIL random_%0d done=%0d pos=%0d,%0d vel=%0d,%0d hit=%b want %0d,%0d %0d,%0d %b",
                 it, g, pos_of(0), pos_of(1), vel_of(0), vel_of(1), hit,
                 mpos[0] >>> 4, mpos[1] >>> 4, mvel[0], mvel[1], mhit);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    calc = 1'b0;
    load = 1'b0;
    load_pos = '0;
    accel = '0;
    bounce = 1'b0;
    test_reset();
    test_tick_latency();
    test_stop_wall();
    test_bounce_wall();
    test_saturation();
    test_abort();
    test_busy_ignore();
    test_friction();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/motion_integrator_axes.md
Name: motion_integrator_axes

Overview:
- Multi-axis fixed-point kinematics integrator for the teeter ball model; successor to the single-axis position accumulator.
- Per tick: velocity += acceleration (saturated), then position += velocity, with wall clamping in stop or bounce mode.
- One shared adder path is time-multiplexed across axes by a small FSM.
- Sits between the tilt/acceleration logic and the display/collision logic.

Parameters:
- NUM_AXES, 2, number of independent axes.
- WIDTH, 32, width of every position/velocity/acceleration word.
- POSITION_SHIFT, 4, fractional bits of position and velocity.
- RST_VALUE, 50, integer position of every axis after reset.
- POS_MIN, 0, integer lower wall.
- POS_MAX, 100, integer upper wall.
- VEL_LIMIT, 64, velocity magnitude cap in raw fixed-point units.
- FRICTION_SHIFT, 4, damping shift; used only with the optional feature.

Ports:
- CLK  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_calc_time  in  1  tick strobe; starts one integration pass.
- i_load  in  1  load integer positions from i_load_pos.
- i_load_pos  in  NUM_AXES*WIDTH  integer positions, signed; axis k at bits [k*WIDTH +: WIDTH].
- i_accel  in  NUM_AXES*WIDTH  signed fixed-point accelerations; sampled per axis during that axis's VEL step.
- i_bounce_mode  in  1  0 = stop at wall, 1 = reflect velocity; sampled per axis at its POS step.
- o_pos  out  NUM_AXES*WIDTH  integer positions: raw position arithmetically shifted right by POSITION_SHIFT (floor).
- o_vel  out  NUM_AXES*WIDTH  raw signed fixed-point velocities.
- o_hit  out  NUM_AXES  per-axis flag: wall hit during the last completed tick.
- o_busy  out  1  high while a pass is in progress.
- o_done  out  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset (async, i_rst=1):
  - raw pos = RST_VALUE<<POSITION_SHIFT; vel = 0.
  - o_hit = 0, o_busy = 0, o_done = 0; FSM to IDLE.
- FSM states: IDLE, VEL, POS, DONE; axis index k counts 0..NUM_AXES-1.
  - IDLE: on i_calc_time, go to VEL with k=0, clear the hit accumulator, o_busy=1.
  - VEL: v' = sat(v + a_k), saturated to ±VEL_LIMIT using a WIDTH+1 sum (no wrap); go to POS.
  - POS: s = p + v (WIDTH+1 bits).
    - If s < POS_MIN<<SHIFT: p = POS_MIN<<SHIFT; v = 0 (stop) or -v (bounce); hit_k = 1.
    - If s > POS_MAX<<SHIFT: p = POS_MAX<<SHIFT; same velocity rule; hit_k = 1.
    - Otherwise p = s.
    - Then k+1 -> VEL, or after the last axis -> DONE.
  - DONE: o_done=1 for one cycle; o_hit updated from the accumulator; o_busy=0; go to IDLE.
- Latency: 2*NUM_AXES+1 cycles from the i_calc_time edge to the o_done cycle (5 at defaults). o_pos/o_vel for axis k change at the end of its step.
- i_calc_time while o_busy is ignored; no queuing.
- i_load (any state):
  - next edge: raw pos_k = i_load_pos_k<<SHIFT; vel = 0; o_hit = 0; FSM to IDLE.
  - An aborted pass produces no o_done.
  - i_load has priority over a same-cycle i_calc_time.
- Loaded values are not clamped; the next tick clamps them.
- Integer output is floor: raw -1 gives o_pos -1.

Optional Feature:
- Macro: MOTION_INTEGRATOR_FRICTION_EN.
- Defined: VEL step computes v' = sat(v + a - (v >>> FRICTION_SHIFT)), arithmetic shift, same single-cycle step.
- Undefined: v' = sat(v + a); FRICTION_SHIFT is unused and no damping logic is built.

Decomposition:
- Shared package motion_pkg:
  - FSM state enum (IDLE/VEL/POS/DONE).
  - Function for the saturating signed add.
  - Function to_int (arithmetic shift by POSITION_SHIFT), reused by the display logic.
- One natural sub-module: axis_clamp. Combinational; takes s, v and the mode; returns the new p, new v and hit. Instantiated once on the shared datapath.

Test Plan:
1. Reset, then tick with accel {16,-16} -> o_done exactly 5 cycles later; o_vel {16,-16}; o_pos {51,49}; o_hit 0.
2. Stop-mode upper wall: load {99,0}, accel {32,0}, tick -> o_pos[0]=100, o_vel[0]=0, o_hit[0]=1.
3. Bounce-mode lower wall: load {0,1}, accel {0,-48}, bounce=1, tick -> o_pos[1]=0, o_vel[1]=+48, o_hit[1]=1.
4. Velocity saturation: accel {100,-100} from rest -> o_vel {64,-64}; o_pos {54,46} (from 50).
5. Abort: i_load asserted in the cycle after the tick starts, positions {10,20} -> no o_done; o_pos {10,20}; o_vel 0; o_busy 0 next cycle.
6. Busy ignore and friction: i_calc_time held 3 cycles -> exactly one o_done.
   - With MOTION_INTEGRATOR_FRICTION_EN, vel 32 and accel 0 -> vel 30 after one tick.
